uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (start/data/done handshake, done high = idle) between NUM_REQ byte requesters.
- Round-robin grant; latches the winner's byte; holds tx_start until the transmitter accepts, waits for frame completion, then acks the requester.
- Sits between command/debug sources and the single Basys3 TX pin transmitter.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types and helpers for the UART transmit arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_t;

  // Width of a counter that must hold values 0 .. timeout-1.
  function automatic int timeout_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin pick over N request lines. The winner is the
//                first set request scanning upward from pointer+1 with wrap.
//                The pointer moves to the winner when update is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             update,
  output logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     winner_onehot
);

  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Scan candidates pointer+1, pointer+2, ... (mod N); first requester wins.
  always_comb begin
    winner_onehot = '0;
    win_idx       = pointer;
    cand          = pointer;
    found         = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = PTR_W'((int'(pointer) + k) % N);
      if (!found && req[cand]) begin
        found                = 1'b1;
        win_idx              = cand;
        winner_onehot[cand]  = 1'b1;
      end
    end
  end

  // Last-served pointer; starts at N-1 so requester 0 has first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pointer <= PTR_W'(N - 1);
    end else if (update) begin
      pointer <= win_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between NUM_REQ byte sources.
//                Round-robin grant, byte latch, start/done handshake with a
//                synchronised done flag and an acceptance timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int ACCEPT_TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic                      busy,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_done
);

  localparam int               TO_W    = timeout_cnt_w(ACCEPT_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACCEPT_TIMEOUT - 1);
  localparam int               PTR_W   = $clog2(NUM_REQ);

  arb_state_t               state;
  logic [TO_W-1:0]          cnt;
  logic                     abort;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     done_s;
  logic [NUM_REQ-1:0]       winner_onehot;
  logic [PTR_W-1:0]         rr_ptr;
  logic [NUM_REQ-1:0]       ptr_onehot;
  logic [BYTE_W-1:0]        pick_byte;
  logic                     take;

  // tx_done comes from the divided transmitter clock; preset idle on reset.
  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      // Single-flop synchroniser.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 1'b1;
        else       sync_q <= tx_done;
      end
    end else begin : g_sync_chain
      // Multi-flop synchroniser chain.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], tx_done};
      end
    end
  endgenerate

  assign done_s = sync_q[SYNC_STAGES-1];

  // A new grant is only taken when the transmitter is seen idle.
  assign take = (state == ST_IDLE) && (|req) && done_s;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk           (clk),
    .rst           (reset),
    .req           (req),
    .update        (take),
    .pointer       (rr_ptr),
    .winner_onehot (winner_onehot)
  );

  // After a grant the pointer equals the winner, so it names the ack bit.
  assign ptr_onehot = NUM_REQ'(1) << rr_ptr;

  // Select the winning requester's byte.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_onehot[i]) pick_byte = pick_byte | req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign busy = (state != ST_IDLE);

  // Transaction FSM: grant, hold start until accepted, wait frame, ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      ack      <= '0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      cnt      <= '0;
      abort    <= 1'b0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            grant    <= winner_onehot;
            tx_data  <= pick_byte;
            tx_start <= 1'b1;
            cnt      <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (!done_s) begin
            tx_start <= 1'b0;
            cnt      <= '0;
            state    <= ST_WAIT;
          end else if (cnt == TO_LAST) begin
            tx_start <= 1'b0;
            abort    <= 1'b1;
            ack      <= ptr_onehot;
            err      <= 1'b1;
            state    <= ST_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (done_s) begin
            ack   <= ptr_onehot;
            err   <= abort;
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          grant <= '0;
          abort <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter with a behavioural
//                transmitter and a round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SYNC    = 2;
  localparam int TOUT    = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     req;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     ack;
  logic                   err;
  logic                   busy;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   tx_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acks   = 0;

  // Reference model state
  int                   model_ptr = NUM_REQ - 1;
  bit                   pending   = 1'b0;
  logic [NUM_REQ-1:0]   prev_req  = '0;
  logic [8*NUM_REQ-1:0] prev_data = '0;
  logic [NUM_REQ-1:0]   prev_grant = '0;
  logic [7:0]           exp_byte  = '0;
  bit                   exp_err   = 1'b0;
  bit                   tx_dead   = 1'b0;
  int                   mon_w;
  int                   grant_log[$];
  logic [7:0]           sent_q[$];

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .SYNC_STAGES    (SYNC),
    .ACCEPT_TIMEOUT (TOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round robin rule: first set request after ptr, wrapping.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (ptr + k) % NUM_REQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Behavioural transmitter: accepts after a random delay, sends a frame.
  initial begin
    int d;
    tx_done = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!tx_dead && tx_start && tx_done) begin
        d = $urandom_range(1, 8);
        repeat (d) @(posedge clk);
        #1;
        check("tx_start_hold", tx_start, 1);
        if (tx_start) begin
          check("tx_byte", tx_data, exp_byte);
          sent_q.push_back(tx_data);
          tx_done = 1'b0;
          repeat ($urandom_range(16, 24)) @(posedge clk);
          #1 tx_done = 1'b1;
        end
      end
    end
  end

  // Scoreboard: every grant, ack and err compared with the model.
  always @(negedge clk) begin
    if (reset) begin
      model_ptr  = NUM_REQ - 1;
      pending    = 1'b0;
      prev_grant = '0;
    end else begin
      check("busy_vs_grant", busy, grant != 0);
      if (grant != 0 && prev_grant == 0) begin
        mon_w = rr_pick(prev_req, model_ptr);
        check("grant_rr", grant, (mon_w < 0) ? 0 : (1 << mon_w));
        if (mon_w >= 0) begin
          model_ptr = mon_w;
          exp_byte  = prev_data[mon_w*8 +: 8];
        end
        check("tx_data_latch", tx_data, exp_byte);
        pending = 1'b1;
        grant_log.push_back(mon_w);
      end else if (grant != 0) begin
        check("grant_stable", grant, prev_grant);
      end
      if (ack != 0) begin
        check("ack_pending", pending, 1);
        check("ack_bit", ack, grant);
        check("err_value", err, exp_err);
        pending = 1'b0;
        n_acks++;
      end else if (err) begin
        check("err_without_ack", err, 0);
      end
      prev_grant = grant;
    end
    prev_req  = req;
    prev_data = req_data;
  end

  task automatic wait_ack(input int idx);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (ack[idx]) seen = 1'b1;
    end
    check($sformatf("ack%0d_seen", idx), seen, 1);
  endtask

  task automatic wait_tx_low();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (!tx_done) seen = 1'b1;
    end
    check("tx_accepted", seen, 1);
  endtask

  task automatic do_reset();
    for (int c = 0; c < 100 && !tx_done; c++) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    req   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int mark;
    int since;
    int ones1;
    int acks0;
    bit got;
    logic [7:0] exp_seq [5];

    reset = 1'b1; req = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single request, latency and latch
    #1 req = 4'b0001; req_data = 32'h0000_00A5;
    @(posedge clk); @(negedge clk);
    check("t1_grant", grant, 4'b0001);
    check("t1_tx_start", tx_start, 1);
    check("t1_tx_data", tx_data, 8'hA5);
    wait_ack(0);
    @(posedge clk); #1 req = '0;

    // All four requesting continuously
    do_reset();
    sent_q.delete();
    req_data = 32'h1312_1110; req = 4'b1111;
    for (int n = 0; n < 5; n++) wait_ack(n % 4);
    @(posedge clk); #1 req = '0;
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    check("t2_sent_count", sent_q.size(), 5);
    for (int n = 0; n < 5 && n < sent_q.size(); n++)
      check($sformatf("t2_byte%0d", n), sent_q[n], exp_seq[n]);

    // Fairness: req0 held, req2 joins mid-frame
    do_reset();
    req_data = 32'h4433_2211; req = 4'b0001;
    wait_tx_low();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 req[2] = 1'b1;
    wait_ack(0);
    mark = grant_log.size();
    wait_ack(2);
    @(posedge clk); #1 req[2] = 1'b0;
    wait_ack(0);
    @(posedge clk); #1 req = '0;
    check("t3_log_len", grant_log.size() >= mark + 2, 1);
    if (grant_log.size() >= mark + 2) begin
      check("t3_next_is_2", grant_log[mark], 2);
      check("t3_then_0", grant_log[mark+1], 0);
    end

    // Acceptance timeout with a dead transmitter
    do_reset();
    tx_dead = 1'b1; exp_err = 1'b1;
    req = 4'b0010; req_data = 32'h0000_7700;
    @(posedge clk); @(negedge clk);
    check("t4_grant", grant, 4'b0010);
    cnt = 0;
    while (tx_start && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("t4_start_cycles", cnt, TOUT);
    check("t4_ack", ack, 4'b0010);
    check("t4_err", err, 1);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("t4_busy_low", busy, 0);
    tx_dead = 1'b0; exp_err = 1'b0;

    // Reset during the frame wait
    do_reset();
    req = 4'b0001; req_data = 32'h0000_005A;
    wait_tx_low();
    repeat (4) @(negedge clk);
    check("t5_busy_before", busy, 1);
    @(posedge clk); #1;
    reset = 1'b1; req = '0;
    #1;
    check("t5_rst_grant", grant, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_start", tx_start, 0);
    check("t5_rst_data", tx_data, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    #1 req = 4'b1000; req_data = 32'hC300_0000;
    check("t5_tx_still_busy", tx_done, 0);
    since = -1; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (since >= 0) since++;
      if (since < 0 && tx_done) since = 0;
      if (grant != 0) got = 1'b1;
    end
    check("t5_grant", grant, 4'b1000);
    check("t5_latency", since, SYNC + 1);
    wait_ack(3);
    @(posedge clk); #1 req = '0;

    // Request withdrawn while another is served
    do_reset();
    req = 4'b0001; req_data = 32'h0000_BB01;
    mark = grant_log.size();
    wait_tx_low();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 req[1] = 1'b1;
    @(posedge clk); #1 req[1] = 1'b0;
    wait_ack(0);
    @(posedge clk); #1 req = '0;
    repeat (5) @(negedge clk);
    ones1 = 0;
    for (int n = mark; n < grant_log.size(); n++) if (grant_log[n] == 1) ones1++;
    check("t6_no_grant1", ones1, 0);

    // Randomised traffic against the model
    do_reset();
    acks0 = n_acks;
    for (int cyc = 0; cyc < 6000 && (n_acks - acks0) < 60; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i]) begin
          req[i] = 1'b0;
        end else if (grant[i]) begin
          if ($urandom_range(0, 3) == 0) req_data[i*8 +: 8] = 8'($urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 40) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
    end
    check("rand_progress", (n_acks - acks0) >= 60, 1);
    #1 req = '0;
    repeat (40) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
